// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared types and Gray-code helpers for gray_sync_dec
package gray_pkg;

    typedef enum logic [1:0] {
        S_FILL,
        S_TRACK,
        S_RESYNC
    } state_t;

    localparam int STABLE_CNT = 2;
    // Helpers work on a fixed wide word; callers zero-extend and truncate.
    localparam int GRAY_MAX_W = 32;

    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic onehot_diff(input logic [GRAY_MAX_W-1:0] a,
                                         input logic [GRAY_MAX_W-1:0] b);
        logic [GRAY_MAX_W-1:0] x;
        x = a ^ b;
        return (x != '0) && ((x & (x - GRAY_MAX_W'(1))) == '0);
    endfunction

endpackage

// File: rtl/sync_bus.sv
// rtl/sync_bus.sv - multi-bit flop-chain synchronizer with async active-low reset
module sync_bus #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] ff [SYNC_STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                ff[i] <= '0;
            end
        end else begin
            ff[0] <= d;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                ff[i] <= ff[i-1];
            end
        end
    end

    assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/gray_sync_dec.sv
// rtl/gray_sync_dec.sv - synchronize, check and decode an asynchronous Gray-coded bus
module gray_sync_dec
    import gray_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             clr,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             dir,
    output logic             err,
    output logic             err_sticky
);

    localparam int FW = $clog2(SYNC_STAGES + 1);

    logic [WIDTH-1:0] gs;
    logic [WIDTH-1:0] g_last;
    logic [WIDTH-1:0] cand;
    logic [WIDTH-1:0] gs_bin;
    logic [WIDTH-1:0] cand_bin;
    logic [FW-1:0]    fill_cnt;
    logic [1:0]       stab_cnt;
    logic             one_step;
    logic             err_set;
    state_t           state;

    sync_bus #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (din),
        .q     (gs)
    );

    assign gs_bin   = WIDTH'(gray2bin(GRAY_MAX_W'(gs)));
    assign cand_bin = WIDTH'(gray2bin(GRAY_MAX_W'(cand)));
    assign one_step = onehot_diff(GRAY_MAX_W'(gs), GRAY_MAX_W'(g_last));
    assign err_set  = (state == S_TRACK) && (gs != g_last) && !one_step;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_FILL;
            fill_cnt   <= '0;
            stab_cnt   <= '0;
            g_last     <= '0;
            cand       <= '0;
            dout       <= '0;
            valid      <= 1'b0;
            dir        <= 1'b0;
            err        <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            valid <= 1'b0;
            err   <= err_set;
            // A pending or just-issued error overrides a simultaneous clear.
            err_sticky <= err_set | err | (err_sticky & ~clr);
            case (state)
                S_FILL: begin
                    if (fill_cnt == FW'(SYNC_STAGES)) begin
                        g_last <= gs;
                        dout   <= gs_bin;
                        valid  <= 1'b1;
                        state  <= S_TRACK;
                    end else begin
                        fill_cnt <= fill_cnt + FW'(1);
                    end
                end
                S_TRACK: begin
                    if (one_step) begin
                        g_last <= gs;
                        dout   <= gs_bin;
                        valid  <= 1'b1;
                        dir    <= (gs_bin == dout + WIDTH'(1));
                    end else if (err_set) begin
                        cand     <= gs;
                        stab_cnt <= '0;
                        state    <= S_RESYNC;
                    end
                end
                S_RESYNC: begin
                    if (gs != cand) begin
                        cand     <= gs;
                        stab_cnt <= '0;
                    end else if (stab_cnt == 2'(STABLE_CNT - 1)) begin
                        g_last <= cand;
                        dout   <= cand_bin;
                        valid  <= 1'b1;
                        state  <= S_TRACK;
                    end else begin
                        stab_cnt <= stab_cnt + 2'd1;
                    end
                end
                default: state <= S_FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_gray_sync_dec.sv
// tb/tb_gray_sync_dec.sv - self-checking bench for gray_sync_dec
module tb_gray_sync_dec;

    localparam int SS = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] din = 4'b0110;
    logic       clr = 1'b0;
    logic [3:0] dout;
    logic       valid, dir, err, err_sticky;

    int n_tests = 0;
    int n_fail  = 0;

    gray_sync_dec #(.WIDTH(4), .SYNC_STAGES(SS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .clr        (clr),
        .dout       (dout),
        .valid      (valid),
        .dir        (dir),
        .err        (err),
        .err_sticky (err_sticky)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] din;
        int         hold;
        int         dout;
        int         dir;
        int         nvalid;
        int         nerr;
    } vec_t;

    vec_t tbl[20];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: binary value found by searching the Gray code table.
    function automatic int g2b(input logic [3:0] g);
        for (int i = 0; i < 16; i++) begin
            if (4'(i ^ (i >> 1)) == g) return i;
        end
        return 0;
    endfunction

    function automatic logic [3:0] b2g(input int b);
        return 4'(b ^ (b >> 1));
    endfunction

    logic [3:0] samp[$];
    int   m_n, m_mode, m_dout, m_dir, m_valid, m_err, m_sticky, m_run;
    logic [3:0] m_glast, m_cand;

    task automatic model_reset();
        samp.delete();
        m_n = 0; m_mode = 0; m_dout = 0; m_dir = 0;
        m_valid = 0; m_err = 0; m_sticky = 0; m_run = 0;
        m_glast = 4'd0; m_cand = 4'd0;
    endtask

    // One clock edge of the behavioural model; gs seen at edge n is din from edge n-SS.
    task automatic model_edge(input logic clr_v);
        logic [3:0] g;
        int gb, hd, new_err, prev_err;
        m_n++;
        g = (m_n - 1 - SS >= 0) ? samp[m_n-1-SS] : 4'd0;
        gb = g2b(g);
        prev_err = m_err;
        new_err = 0;
        m_valid = 0;
        if (m_mode == 0) begin
            if (m_n == SS + 1) begin
                m_dout = gb; m_glast = g; m_valid = 1; m_mode = 1;
            end
        end else if (m_mode == 1) begin
            hd = $countones(g ^ m_glast);
            if (hd == 1) begin
                m_dir = (gb == (m_dout + 1) % 16) ? 1 : 0;
                m_dout = gb; m_glast = g; m_valid = 1;
            end else if (hd > 1) begin
                new_err = 1; m_mode = 2; m_cand = g; m_run = 1;
            end
        end else begin
            if (g == m_cand) m_run++;
            else begin m_cand = g; m_run = 1; end
            if (m_run == 3) begin
                m_dout = g2b(m_cand); m_glast = m_cand; m_valid = 1; m_mode = 1;
            end
        end
        m_err = new_err;
        if (new_err != 0 || prev_err != 0) m_sticky = 1;
        else if (clr_v) m_sticky = 0;
    endtask

    initial begin
        int nv, ne, b, r;
        tbl[0] = '{4'b0001, 4, 1, 1, 1, 0};
        tbl[1] = '{4'b0011, 4, 2, 1, 1, 0};
        tbl[2] = '{4'b0010, 4, 3, 1, 1, 0};
        tbl[3] = '{4'b0110, 4, 4, 1, 1, 0};
        tbl[4] = '{4'b0111, 4, 5, 1, 1, 0};
        tbl[5] = '{4'b0101, 4, 6, 1, 1, 0};
        tbl[6] = '{4'b0100, 4, 7, 1, 1, 0};
        tbl[7] = '{4'b1100, 4, 8, 1, 1, 0};
        tbl[8] = '{4'b1101, 4, 9, 1, 1, 0};
        tbl[9] = '{4'b1111, 4, 10, 1, 1, 0};
        tbl[10] = '{4'b1110, 4, 11, 1, 1, 0};
        tbl[11] = '{4'b1010, 4, 12, 1, 1, 0};
        tbl[12] = '{4'b1011, 4, 13, 1, 1, 0};
        tbl[13] = '{4'b1001, 4, 14, 1, 1, 0};
        tbl[14] = '{4'b1000, 4, 15, 1, 1, 0};
        tbl[15] = '{4'b0000, 4, 0, 1, 1, 0};
        tbl[16] = '{4'b1000, 4, 15, 0, 1, 0};
        tbl[17] = '{4'b0000, 4, 0, 1, 1, 0};
        tbl[18] = '{4'b0001, 4, 1, 1, 1, 0};
        tbl[19] = '{4'b0111, 6, 5, 1, 1, 1};

        // Reset state and fill with din=0110
        #2;
        chk("reset_outputs", {dout, valid, dir, err, err_sticky}, 0);
        tick();
        rst_n = 1'b1;
        tick(); tick();
        chk("fill_no_early_valid", valid, 0);
        tick();
        chk("fill_valid", valid, 1);
        chk("fill_dout", dout, 4);
        chk("fill_err", err, 0);
        tick();
        chk("fill_single_valid", valid, 0);

        // Restart from zero for the sweep
        rst_n = 1'b0; din = 4'b0000;
        tick();
        rst_n = 1'b1;
        tick(); tick(); tick();
        chk("refill_dout", dout, 0);

        for (int i = 0; i < 20; i++) begin
            din = tbl[i].din;
            nv = 0; ne = 0;
            for (int c = 0; c < tbl[i].hold; c++) begin
                tick();
                nv += int'(valid);
                ne += int'(err);
                if (valid && err) chk("valid_err_overlap", 1, 0);
            end
            chk($sformatf("tbl%0d_dout", i), dout, tbl[i].dout);
            chk($sformatf("tbl%0d_dir", i), dir, tbl[i].dir);
            chk($sformatf("tbl%0d_valids", i), nv, tbl[i].nvalid);
            chk($sformatf("tbl%0d_errs", i), ne, tbl[i].nerr);
        end
        chk("sticky_after_jump", err_sticky, 1);

        // Sticky clear with no new error
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("sticky_cleared", err_sticky, 0);

        // New illegal jump 0111 -> 0000, clr while err is high
        din = 4'b0000;
        tick(); tick(); tick();
        chk("jump2_err", err, 1);
        chk("jump2_sticky", err_sticky, 1);
        chk("jump2_dout_hold", dout, 5);
        chk("jump2_no_valid", valid, 0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("sticky_set_wins", err_sticky, 1);
        tick();
        chk("resync_valid", valid, 1);
        chk("resync_dout", dout, 0);
        chk("resync_dir", dir, 1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("sticky_cleared2", err_sticky, 0);

        // Async reset mid-stream
        din = 4'b0001;
        repeat (4) tick();
        din = 4'b0011;
        repeat (4) tick();
        chk("pre_reset_dout", dout, 2);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", {dout, valid, dir, err, err_sticky}, 0);
        tick();
        din = 4'b0010;
        rst_n = 1'b1;
        tick(); tick();
        chk("rerun_no_early_valid", valid, 0);
        tick();
        chk("rerun_valid", valid, 1);
        chk("rerun_dout", dout, 3);
        chk("rerun_dir", dir, 0);

        // Randomized walk against the model
        rst_n = 1'b0; clr = 1'b0;
        b = $urandom_range(0, 15);
        din = b2g(b);
        tick();
        rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < 800; k++) begin
            r = $urandom_range(0, 99);
            if (r < 40) b = b;
            else if (r < 65) b = (b + 1) % 16;
            else if (r < 92) b = (b + 15) % 16;
            else b = $urandom_range(0, 15);
            din = b2g(b);
            clr = ($urandom_range(0, 15) == 0);
            samp.push_back(din);
            tick();
            model_edge(clr);
            chk($sformatf("rand%0d", k), {dout, valid, dir, err, err_sticky},
                {4'(m_dout), 1'(m_valid), 1'(m_dir), 1'(m_err), 1'(m_sticky)});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
